press_arbiter: RTL and testbench
================================

PRESS_ARBITER -- requirements
Module: press_arbiter

Interface
REQ-001 Parameter SPEED_TARGET, default 8, presses needed to win a speed round (range 1..2^CNT_W-1).
REQ-002 Parameter HOLD_TICKS, default 2, slowen256 pulses winspeed is held before speed_exit.
REQ-003 Parameter CNT_W, default 4, press-counter width.
REQ-004 clk  in  1  system clock, all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 pb_l, pb_r  in  1 each  raw player buttons, asynchronous, active-high.
REQ-007 clear  in  1  from game controller; 1 = disarm round logic.
REQ-008 speed_round  in  1  from game controller; 1 = speed round active.
REQ-009 slowen256  in  1  one-clk enable pulse, slow timebase.
REQ-010 winrnd  out  1  level; a player won the normal round.
REQ-011 winspeed  out  1  level; a player reached SPEED_TARGET.
REQ-012 speed_exit  out  1  one-clk pulse; speed display hold finished.
REQ-013 winner  out  1  0 = left, 1 = right; last decided winner.
REQ-014 tie  out  1  one-clk pulse; simultaneous decision resolved by priority.
REQ-015 cnt_l, cnt_r  out  CNT_W each  speed-round press counts.

Function
REQ-016 Each button SHALL pass a 2-flop synchronizer then rising-edge detect; only edges count, held buttons never retrigger.
REQ-017 States SHALL be IDLE, ARMED, LOCKED, SPEED, SPEED_DONE, SPEED_EXIT.
REQ-018 IDLE: if speed_round=1 -> SPEED (counters cleared); else if clear=0 -> ARMED.
REQ-019 ARMED: speed_round=1 -> SPEED; else clear=1 -> IDLE; else any press edge -> LOCKED, winner latched.
REQ-020 A button held before arming SHALL NOT win; only an edge occurring while in ARMED wins.
REQ-021 LOCKED: winrnd=1 held; clear=1 -> IDLE; presses ignored.
REQ-022 Raw press first sampled high at edge k SHALL give winrnd=1 after edge k+2 (ARMED throughout).
REQ-023 Both edges in the same cycle: winner = tie_pri, tie pulses, tie_pri toggles; tie_pri = left (0) after reset.
REQ-024 SPEED: each edge increments that player's counter; both edges same cycle increment both.
REQ-025 First counter to equal SPEED_TARGET -> SPEED_DONE, winner latched; both reaching it same cycle resolved per REQ-023.
REQ-026 Counters SHALL stop at SPEED_TARGET and never wrap.
REQ-027 SPEED with speed_round=0 before a winner -> IDLE, no winspeed, winner unchanged.
REQ-028 SPEED_DONE: winspeed=1 held; count slowen256 pulses; on the HOLD_TICKS-th pulse -> SPEED_EXIT; speed_round ignored.
REQ-029 SPEED_EXIT: speed_exit=1 for exactly one clk, counters cleared, -> IDLE next edge.
REQ-030 winner SHALL hold its value until the next decision; cnt_l/cnt_r hold through SPEED_DONE.
REQ-031 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-032 rst asserted at any time SHALL force IDLE, winrnd=0, winspeed=0, speed_exit=0, tie=0, winner=0, tie_pri=0, cnt_l=cnt_r=0, hold count=0, sync flops=0.
REQ-033 After rst release, a button already high SHALL NOT produce an edge.

Structure
REQ-034 State encoding, player ID constants (LEFT=0, RIGHT=1) and parameter defaults SHALL live in shared package tow_pkg.
REQ-035 Synchronizer plus edge detect SHALL be sub-module btn_sync, instantiated once per button.

Verification
REQ-036 clear=0, pb_r rises at edge 10 -> winrnd=1 after edge 12, winner=1; clear=1 -> winrnd=0 next cycle.
REQ-037 pb_l held before and through arming, then pb_r rises -> winner=1; pb_l never wins.
REQ-038 ARMED, pb_l and pb_r rise same cycle twice (with clear between) -> first winner=0, second winner=1, tie pulses each time.
REQ-039 speed_round=1, SPEED_TARGET=8, pb_l 8 presses, pb_r 5 -> winspeed=1, winner=0, cnt_l=8, cnt_r=5; after 2 slowen256 pulses speed_exit one-clk pulse, then IDLE.
REQ-040 speed_round drops after 3 left presses -> IDLE, winspeed never 1, winner unchanged.
REQ-041 rst pulsed mid-SPEED_DONE -> all outputs 0 within same cycle, IDLE after release.

Source files
------------

// File: rtl/tow_pkg.sv
`default_nettype none
// tow_pkg: shared state encoding, player IDs and parameter defaults for the press arbiter.
package tow_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ARMED      = 3'd1,
    LOCKED     = 3'd2,
    SPEED      = 3'd3,
    SPEED_DONE = 3'd4,
    SPEED_EXIT = 3'd5
  } state_t;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  localparam int SPEED_TARGET_DEF = 8;
  localparam int HOLD_TICKS_DEF   = 2;
  localparam int CNT_W_DEF        = 4;

endpackage
`default_nettype wire

// File: rtl/btn_sync.sv
`default_nettype none
// btn_sync: two-flop synchronizer plus rising-edge detect for one raw push button.
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic       meta;
  logic       sync;
  logic       prev;
  logic [2:0] ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      prev  <= 1'b0;
      ready <= 3'b000;
    end else begin
      meta  <= btn;
      sync  <= meta;
      prev  <= sync;
      ready <= {ready[1:0], 1'b1};
    end
  end

  // Edges are masked until prev holds a real sample, so a button already
  // down when reset releases never looks like a fresh press.
  assign press = sync & ~prev & ready[2];

endmodule
`default_nettype wire

// File: rtl/press_arbiter.sv
`default_nettype none
// press_arbiter: decides the first-press winner of a normal round and the first
// player to reach SPEED_TARGET presses in a speed round.
module press_arbiter
  import tow_pkg::*;
#(
  parameter int SPEED_TARGET = SPEED_TARGET_DEF,
  parameter int HOLD_TICKS   = HOLD_TICKS_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pb_l,
  input  logic             pb_r,
  input  logic             clear,
  input  logic             speed_round,
  input  logic             slowen256,
  output logic             winrnd,
  output logic             winspeed,
  output logic             speed_exit,
  output logic             winner,
  output logic             tie,
  output logic [CNT_W-1:0] cnt_l,
  output logic [CNT_W-1:0] cnt_r
);

  localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [CNT_W-1:0]  TARGET    = CNT_W'(SPEED_TARGET);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

  state_t            state, state_n;
  logic              press_l, press_r;
  logic              winner_n, tie_n, tie_pri, tie_pri_n;
  logic [CNT_W-1:0]  cnt_l_n, cnt_r_n, inc_l, inc_r;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic              hit_l, hit_r;

  btn_sync u_sync_l (.clk(clk), .rst(rst), .btn(pb_l), .press(press_l));
  btn_sync u_sync_r (.clk(clk), .rst(rst), .btn(pb_r), .press(press_r));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      winner     <= LEFT;
      tie_pri    <= LEFT;
      tie        <= 1'b0;
      cnt_l      <= '0;
      cnt_r      <= '0;
      hold_cnt   <= '0;
      winrnd     <= 1'b0;
      winspeed   <= 1'b0;
      speed_exit <= 1'b0;
    end else begin
      state      <= state_n;
      winner     <= winner_n;
      tie_pri    <= tie_pri_n;
      tie        <= tie_n;
      cnt_l      <= cnt_l_n;
      cnt_r      <= cnt_r_n;
      hold_cnt   <= hold_n;
      winrnd     <= (state_n == LOCKED);
      winspeed   <= (state_n == SPEED_DONE);
      speed_exit <= (state_n == SPEED_EXIT);
    end
  end

  always_comb begin
    state_n   = state;
    winner_n  = winner;
    tie_pri_n = tie_pri;
    tie_n     = 1'b0;
    cnt_l_n   = cnt_l;
    cnt_r_n   = cnt_r;
    hold_n    = hold_cnt;
    // Saturating increments: a counter sitting at the target ignores presses.
    inc_l     = cnt_l + CNT_W'(press_l && (cnt_l != TARGET));
    inc_r     = cnt_r + CNT_W'(press_r && (cnt_r != TARGET));
    hit_l     = (inc_l == TARGET);
    hit_r     = (inc_r == TARGET);

    case (state)
      IDLE: begin
        if (speed_round) begin
          state_n = SPEED;
          cnt_l_n = '0;
          cnt_r_n = '0;
        end else if (!clear) begin
          state_n = ARMED;
        end
      end
      ARMED: begin
        if (speed_round) begin
          state_n = SPEED;
          cnt_l_n = '0;
          cnt_r_n = '0;
        end else if (clear) begin
          state_n = IDLE;
        end else if (press_l || press_r) begin
          state_n = LOCKED;
          if (press_l && press_r) begin
            winner_n  = tie_pri;
            tie_n     = 1'b1;
            tie_pri_n = ~tie_pri;
          end else begin
            winner_n = press_r ? RIGHT : LEFT;
          end
        end
      end
      LOCKED: begin
        if (clear) state_n = IDLE;
      end
      SPEED: begin
        if (!speed_round) begin
          state_n = IDLE;
        end else begin
          cnt_l_n = inc_l;
          cnt_r_n = inc_r;
          if (hit_l || hit_r) begin
            state_n = SPEED_DONE;
            hold_n  = '0;
            if (hit_l && hit_r) begin
              winner_n  = tie_pri;
              tie_n     = 1'b1;
              tie_pri_n = ~tie_pri;
            end else begin
              winner_n = hit_r ? RIGHT : LEFT;
            end
          end
        end
      end
      SPEED_DONE: begin
        if (slowen256) begin
          if (hold_cnt == HOLD_LAST) begin
            state_n = SPEED_EXIT;
            hold_n  = '0;
            cnt_l_n = '0;
            cnt_r_n = '0;
          end else begin
            hold_n = hold_cnt + HOLD_W'(1);
          end
        end
      end
      SPEED_EXIT: state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_press_arbiter.sv
`default_nettype none
// tb_press_arbiter: randomized self-checking bench; expectations come from
// scenario-level press counting and the winner/tie-priority rules.
module tb_press_arbiter;
  import tow_pkg::*;

  localparam int T = 8;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst, pb_l, pb_r, clear, speed_round, slowen256;
  logic winrnd, winspeed, speed_exit, winner, tie;
  logic [W-1:0] cnt_l, cnt_r;
  logic [4:0] st;
  logic [4:0] exp_st;
  logic exp_winner;
  logic exp_pri;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  press_arbiter #(.SPEED_TARGET(T), .HOLD_TICKS(2), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .pb_l(pb_l), .pb_r(pb_r), .clear(clear),
    .speed_round(speed_round), .slowen256(slowen256), .winrnd(winrnd),
    .winspeed(winspeed), .speed_exit(speed_exit), .winner(winner), .tie(tie),
    .cnt_l(cnt_l), .cnt_r(cnt_r)
  );

  // status = {winrnd, winspeed, speed_exit, tie, winner}
  assign st = {winrnd, winspeed, speed_exit, tie, winner};

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_slot(input logic l, input logic r);
    pb_l = l; pb_r = r;
    tick(1);
    pb_l = 1'b0; pb_r = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    rst = 1'b1; pb_l = 1'b0; pb_r = 1'b1; clear = 1'b0;
    speed_round = 1'b0; slowen256 = 1'b0;
    tick(2);
    checks++;
    if (st !== 5'b00000 || {cnt_l, cnt_r} !== '0) begin
      errors++;
      $display("FAIL reset_state: got st=%b l=%0d r=%0d expected st=00000 l=0 r=0", st, cnt_l, cnt_r);
    end
    #3 rst = 1'b0;
    tick(8);
    checks++;
    if (st !== 5'b00000) begin
      errors++;
      $display("FAIL held_through_reset: got st=%b expected st=00000", st);
    end
    pb_r = 1'b0; clear = 1'b1;
    tick(3);
    exp_winner = LEFT; exp_pri = LEFT;
  endtask

  task automatic test_normal_round();
    logic p;
    for (int i = 0; i < 6; i++) begin
      p = (i == 0) ? RIGHT : logic'($urandom_range(0, 1));
      clear = 1'b0;
      tick(1);
      tick($urandom_range(0, 4));
      if (p) pb_r = 1'b1; else pb_l = 1'b1;
      tick(2);
      exp_st = {4'b0000, exp_winner};
      checks++;
      if (st !== exp_st) begin
        errors++;
        $display("FAIL round_latency: got st=%b expected st=%b", st, exp_st);
      end
      tick(1);
      exp_winner = p;
      exp_st = {4'b1000, exp_winner};
      checks++;
      if (st !== exp_st) begin
        errors++;
        $display("FAIL round_win: got st=%b expected st=%b", st, exp_st);
      end
      pb_l = 1'b0; pb_r = 1'b0;
      tick(1);
      if (p) pb_l = 1'b1; else pb_r = 1'b1;
      tick(3);
      checks++;
      if (st !== exp_st) begin
        errors++;
        $display("FAIL locked_ignores: got st=%b expected st=%b", st, exp_st);
      end
      pb_l = 1'b0; pb_r = 1'b0; clear = 1'b1;
      tick(1);
      exp_st = {4'b0000, exp_winner};
      checks++;
      if (st !== exp_st) begin
        errors++;
        $display("FAIL round_clear: got st=%b expected st=%b", st, exp_st);
      end
      tick(3);
    end
  endtask

  task automatic test_held_button();
    clear = 1'b1; pb_l = 1'b1;
    tick(3);
    clear = 1'b0;
    tick(5);
    exp_st = {4'b0000, exp_winner};
    checks++;
    if (st !== exp_st) begin
      errors++;
      $display("FAIL held_no_win: got st=%b expected st=%b", st, exp_st);
    end
    pb_r = 1'b1;
    tick(3);
    exp_winner = RIGHT;
    exp_st = {4'b1000, exp_winner};
    checks++;
    if (st !== exp_st) begin
      errors++;
      $display("FAIL held_other_wins: got st=%b expected st=%b", st, exp_st);
    end
    pb_l = 1'b0; pb_r = 1'b0; clear = 1'b1;
    tick(3);
  endtask

  task automatic test_tie();
    for (int i = 0; i < 4; i++) begin
      clear = 1'b0;
      tick(1 + $urandom_range(0, 3));
      pb_l = 1'b1; pb_r = 1'b1;
      tick(3);
      exp_winner = exp_pri;
      exp_st = {4'b1001, exp_winner};
      checks++;
      if (st !== exp_st) begin
        errors++;
        $display("FAIL tie_decide: got st=%b expected st=%b", st, exp_st);
      end
      exp_pri = ~exp_pri;
      tick(1);
      exp_st = {4'b1000, exp_winner};
      checks++;
      if (st !== exp_st) begin
        errors++;
        $display("FAIL tie_one_pulse: got st=%b expected st=%b", st, exp_st);
      end
      pb_l = 1'b0; pb_r = 1'b0; clear = 1'b1;
      tick(3);
    end
  endtask

  task automatic test_speed();
    int ml, mr, slot;
    logic [1:0] b;
    logic hl, hr, exp_tie;
    for (int s = 0; s < 5; s++) begin
      ml = 0; mr = 0; slot = 0; hl = 1'b0; hr = 1'b0;
      clear = 1'b1; speed_round = 1'b1;
      tick(1);
      while (!hl && !hr && slot < 40) begin
        if (s == 0) b = (slot < 5) ? 2'b11 : 2'b01;
        else        b = 2'($urandom_range(1, 3));
        press_slot(b[0], b[1]);
        checks++;
        if ({winspeed, cnt_l, cnt_r} !== {1'b0, W'(ml), W'(mr)}) begin
          errors++;
          $display("FAIL speed_count: got ws=%b l=%0d r=%0d expected ws=0 l=%0d r=%0d",
                   winspeed, cnt_l, cnt_r, ml, mr);
        end
        ml += int'(b[0]);
        mr += int'(b[1]);
        hl = (ml == T);
        hr = (mr == T);
        slot++;
      end
      if (hl && hr) begin
        exp_winner = exp_pri; exp_tie = 1'b1; exp_pri = ~exp_pri;
      end else begin
        exp_winner = hr; exp_tie = 1'b0;
      end
      tick(1);
      exp_st = {3'b010, exp_tie, exp_winner};
      checks++;
      if (st !== exp_st || {cnt_l, cnt_r} !== {W'(ml), W'(mr)}) begin
        errors++;
        $display("FAIL speed_win: got st=%b l=%0d r=%0d expected st=%b l=%0d r=%0d",
                 st, cnt_l, cnt_r, exp_st, ml, mr);
      end
      press_slot(1'b1, 1'b1);
      press_slot(1'b1, 1'b0);
      tick(2);
      exp_st = {4'b0100, exp_winner};
      checks++;
      if (st !== exp_st || {cnt_l, cnt_r} !== {W'(ml), W'(mr)}) begin
        errors++;
        $display("FAIL speed_hold: got st=%b l=%0d r=%0d expected st=%b l=%0d r=%0d",
                 st, cnt_l, cnt_r, exp_st, ml, mr);
      end
      slowen256 = 1'b1;
      tick(1);
      slowen256 = 1'b0; speed_round = 1'b0;
      tick($urandom_range(0, 3));
      checks++;
      if (st !== exp_st) begin
        errors++;
        $display("FAIL speed_first_tick: got st=%b expected st=%b", st, exp_st);
      end
      slowen256 = 1'b1;
      tick(1);
      slowen256 = 1'b0;
      exp_st = {4'b0010, exp_winner};
      checks++;
      if (st !== exp_st || {cnt_l, cnt_r} !== '0) begin
        errors++;
        $display("FAIL speed_exit: got st=%b l=%0d r=%0d expected st=%b l=0 r=0",
                 st, cnt_l, cnt_r, exp_st);
      end
      tick(1);
      exp_st = {4'b0000, exp_winner};
      checks++;
      if (st !== exp_st) begin
        errors++;
        $display("FAIL speed_exit_pulse: got st=%b expected st=%b", st, exp_st);
      end
      tick(2);
    end
  endtask

  task automatic test_speed_abort();
    clear = 1'b1; speed_round = 1'b1;
    tick(1);
    repeat (3) press_slot(1'b1, 1'b0);
    tick(1);
    exp_st = {4'b0000, exp_winner};
    checks++;
    if (st !== exp_st || {cnt_l, cnt_r} !== {W'(3), W'(0)}) begin
      errors++;
      $display("FAIL abort_count: got st=%b l=%0d r=%0d expected st=%b l=3 r=0",
               st, cnt_l, cnt_r, exp_st);
    end
    speed_round = 1'b0;
    tick(1);
    repeat (6) press_slot(1'b1, 1'b0);
    tick(2);
    checks++;
    if (st !== exp_st) begin
      errors++;
      $display("FAIL abort_idle: got st=%b expected st=%b", st, exp_st);
    end
  endtask

  task automatic test_reset_mid();
    clear = 1'b1; speed_round = 1'b1;
    tick(1);
    repeat (T) press_slot(1'b1, 1'b0);
    tick(1);
    exp_winner = LEFT;
    checks++;
    if (st !== 5'b01000) begin
      errors++;
      $display("FAIL mid_setup: got st=%b expected st=01000", st);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (st !== 5'b00000 || {cnt_l, cnt_r} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got st=%b l=%0d r=%0d expected st=00000 l=0 r=0", st, cnt_l, cnt_r);
    end
    exp_pri = LEFT;
    #3 rst = 1'b0;
    speed_round = 1'b0;
    tick(4);
    clear = 1'b0;
    tick(1);
    pb_l = 1'b1; pb_r = 1'b1;
    tick(3);
    exp_winner = exp_pri;
    exp_pri = ~exp_pri;
    exp_st = {4'b1001, exp_winner};
    checks++;
    if (st !== exp_st) begin
      errors++;
      $display("FAIL post_reset_tie: got st=%b expected st=%b", st, exp_st);
    end
    pb_l = 1'b0; pb_r = 1'b0; clear = 1'b1;
    tick(3);
  endtask

  initial begin
    test_reset();
    test_normal_round();
    test_held_button();
    test_tie();
    test_speed();
    test_speed_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
